// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I control FSM driving the datapath control lines
// Outputs are combinational from the state and the latched instruction register.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        zero_flag,
  output logic [4:0]  reg1_addr,
  output logic [4:0]  reg2_addr,
  output logic [4:0]  write_reg_addr,
  output logic        ctrl0,
  output logic        ctrl1,
  output logic        ctrl2,
  output logic        ctrl3,
  output logic        ctrl4,
  output logic [2:0]  ALUOp,
  output logic        done,
  output logic        branch_taken,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_SRL = 3'b011;
  localparam logic [2:0] ALU_SRA = 3'b100;
  localparam logic [2:0] ALU_AND = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_XOR = 3'b111;

  state_t      state_q;
  logic [31:0] ir_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       alt;
  logic       is_r, is_i, is_ld, is_st, is_br;
  logic       f3_ok, legal;
  logic [2:0] base_op, exec_op;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];
  assign alt    = (funct7 == 7'b0100000);

  assign reg1_addr      = ir_q[19:15];
  assign reg2_addr      = ir_q[24:20];
  assign write_reg_addr = ir_q[11:7];

  always_comb begin
    is_r  = (opcode == 7'b0110011);
    is_i  = (opcode == 7'b0010011);
    is_ld = (opcode == 7'b0000011) && (funct3 == 3'b010);
    is_st = (opcode == 7'b0100011) && (funct3 == 3'b010);
    is_br = (opcode == 7'b1100011) && (funct3[2:1] == 2'b00);
    f3_ok = (funct3[2:1] != 2'b01);
    // addi keeps add even when its immediate happens to look like funct7=0100000
    case (funct3)
      3'b000:  base_op = (is_r && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  base_op = ALU_OR;
      3'b111:  base_op = ALU_AND;
      default: base_op = ALU_ADD;
    endcase
    legal = is_ld || is_st || is_br
         || (is_r && f3_ok && ((funct7 == 7'b0) || (alt && (funct3 == 3'b000 || funct3 == 3'b101))))
         || (is_i && f3_ok && ((funct3 == 3'b001) ? (funct7 == 7'b0) :
                               (funct3 == 3'b101) ? ((funct7 == 7'b0) || alt) : 1'b1));
    if (is_ld || is_st)  exec_op = ALU_ADD;
    else if (is_br)      exec_op = ALU_SUB;
    else                 exec_op = base_op;
  end

  always_comb begin
    instr_ready  = (state_q == S_IDLE) && !reset;
    ctrl0        = 1'b0;
    ctrl1        = 1'b1;
    ctrl2        = 1'b0;
    ctrl3        = 1'b0;
    ctrl4        = 1'b0;
    ALUOp        = ALU_ADD;
    done         = 1'b0;
    branch_taken = 1'b0;
    illegal      = 1'b0;
    case (state_q)
      S_DECODE: begin
        done    = !legal;
        illegal = !legal;
      end
      S_EXECUTE: begin
        ctrl2 = is_i || is_ld || is_st;
        ALUOp = exec_op;
        if (is_br) begin
          done         = 1'b1;
          branch_taken = funct3[0] ? !zero_flag : zero_flag;
        end
      end
      S_MEMORY: begin
        ctrl2 = 1'b1;
        ALUOp = exec_op;
        ctrl3 = is_ld;
        ctrl4 = is_st;
        done  = is_st;
      end
      S_WRITEBACK: begin
        ctrl2 = is_i || is_ld;
        ALUOp = exec_op;
        ctrl0 = (write_reg_addr != 5'd0);
        ctrl1 = !is_ld;
        ctrl3 = is_ld;
        done  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ir_q    <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            ir_q    <= instruction;
            state_q <= S_DECODE;
          end
        end
        S_DECODE:  state_q <= legal ? S_EXECUTE : S_IDLE;
        S_EXECUTE: begin
          if (is_br)               state_q <= S_IDLE;
          else if (is_ld || is_st) state_q <= S_MEMORY;
          else                     state_q <= S_WRITEBACK;
        end
        S_MEMORY:    state_q <= is_ld ? S_WRITEBACK : S_IDLE;
        S_WRITEBACK: state_q <= S_IDLE;
        default:     state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized self-checking bench for multicycle_ctrl
// Expected outputs come from a per-instruction cycle-index model, compared every cycle.
module tb_multicycle_ctrl;

  localparam int K_ILL = 0, K_R = 1, K_I = 2, K_LD = 3, K_ST = 4, K_BR = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic        zero_flag;
  logic [4:0]  reg1_addr, reg2_addr, write_reg_addr;
  logic        ctrl0, ctrl1, ctrl2, ctrl3, ctrl4;
  logic [2:0]  ALUOp;
  logic        done, branch_taken, illegal;

  int tests_run = 0;
  int tests_failed = 0;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .zero_flag(zero_flag), .reg1_addr(reg1_addr),
    .reg2_addr(reg2_addr), .write_reg_addr(write_reg_addr), .ctrl0(ctrl0),
    .ctrl1(ctrl1), .ctrl2(ctrl2), .ctrl3(ctrl3), .ctrl4(ctrl4), .ALUOp(ALUOp),
    .done(done), .branch_taken(branch_taken), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs();
    return {5'd0, instr_ready, reg1_addr, reg2_addr, write_reg_addr,
            ctrl0, ctrl1, ctrl2, ctrl3, ctrl4, ALUOp, done, branch_taken, illegal};
  endfunction

  // Classify a word by mnemonic rules and give the ALU operation it must use.
  function automatic void ref_decode(input logic [31:0] w, output int kind, output logic [2:0] op);
    logic [6:0] opc = w[6:0];
    logic [2:0] f3  = w[14:12];
    logic [6:0] f7  = w[31:25];
    kind = K_ILL;
    op   = 3'b000;
    if (opc == 7'b0110011) begin
      if (f7 == 7'h00) begin
        case (f3)
          3'd0: begin kind = K_R; op = 3'b000; end
          3'd1: begin kind = K_R; op = 3'b010; end
          3'd4: begin kind = K_R; op = 3'b111; end
          3'd5: begin kind = K_R; op = 3'b011; end
          3'd6: begin kind = K_R; op = 3'b110; end
          3'd7: begin kind = K_R; op = 3'b101; end
          default: kind = K_ILL;
        endcase
      end else if (f7 == 7'h20 && f3 == 3'd0) begin kind = K_R; op = 3'b001; end
      else if (f7 == 7'h20 && f3 == 3'd5)     begin kind = K_R; op = 3'b100; end
    end else if (opc == 7'b0010011) begin
      case (f3)
        3'd0: begin kind = K_I; op = 3'b000; end
        3'd4: begin kind = K_I; op = 3'b111; end
        3'd6: begin kind = K_I; op = 3'b110; end
        3'd7: begin kind = K_I; op = 3'b101; end
        3'd1: if (f7 == 7'h00) begin kind = K_I; op = 3'b010; end
        3'd5: begin
          if (f7 == 7'h00)      begin kind = K_I; op = 3'b011; end
          else if (f7 == 7'h20) begin kind = K_I; op = 3'b100; end
        end
        default: kind = K_ILL;
      endcase
    end else if (opc == 7'b0000011 && f3 == 3'd2) begin kind = K_LD; op = 3'b000; end
    else if (opc == 7'b0100011 && f3 == 3'd2)     begin kind = K_ST; op = 3'b000; end
    else if (opc == 7'b1100011 && f3 <= 3'd1)     begin kind = K_BR; op = 3'b001; end
  endfunction

  function automatic int cycles_of(input int kind);
    case (kind)
      K_ILL:   return 1;
      K_BR:    return 2;
      K_LD:    return 4;
      default: return 3;
    endcase
  endfunction

  // Cycle k (1 = decode) of an n-cycle instruction; k = n+1 is the idle cycle after done.
  function automatic logic [31:0] exp_cycle(input logic [31:0] w, input int kind, input logic [2:0] op,
                                            input int n, input int k, input logic zf);
    logic idle = (k > n);
    logic last = (k == n);
    logic c0 = (kind == K_R || kind == K_I || kind == K_LD) && last && (w[11:7] != 5'd0);
    logic c1 = !(kind == K_LD && last);
    logic c2 = (k >= 2) && !idle && (kind == K_I || kind == K_LD || kind == K_ST);
    logic c3 = (kind == K_LD) && (k >= 3) && !idle;
    logic c4 = (kind == K_ST) && (k == 3);
    logic [2:0] aop = ((k >= 2) && !idle) ? op : 3'b000;
    logic bt = (kind == K_BR) && last && (zf ^ w[12]);
    logic il = (kind == K_ILL) && last;
    return {5'd0, idle, w[19:15], w[24:20], w[11:7], c0, c1, c2, c3, c4, aop, last, bt, il};
  endfunction

  task automatic run_instr(input logic [31:0] w, input int zf_mode);
    int kind, n, guard;
    logic [2:0] op;
    ref_decode(w, kind, op);
    n = cycles_of(kind);
    guard = 0;
    while (!instr_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_eq("ready_before", {31'd0, instr_ready}, 32'd1);
    instruction = w;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instruction = $urandom;
    for (int k = 1; k <= n + 1; k++) begin
      zero_flag = (zf_mode < 0) ? 1'($urandom_range(0, 1)) : zf_mode[0];
      @(negedge clk);
      check_eq($sformatf("%08h_c%0d", w, k), obs(), exp_cycle(w, kind, op, n, k, zero_flag));
      if (k <= n) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    int sel = $urandom_range(0, 9);
    int f7s = $urandom_range(0, 3);
    case (sel)
      0, 1: w[6:0] = 7'b0110011;
      2, 3: w[6:0] = 7'b0010011;
      4:    w[6:0] = 7'b0000011;
      5:    w[6:0] = 7'b0100011;
      6:    w[6:0] = 7'b1100011;
      default: ;
    endcase
    if ((sel == 4 || sel == 5) && $urandom_range(0, 3) != 0) w[14:12] = 3'd2;
    if (sel == 6 && $urandom_range(0, 3) != 0) w[14:12] = 3'($urandom_range(0, 1));
    if (f7s == 0) w[31:25] = 7'h00;
    else if (f7s == 1) w[31:25] = 7'h20;
    if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  initial begin
    reset       = 1'b1;
    instruction = 32'd0;
    instr_valid = 1'b0;
    zero_flag   = 1'b0;
    #2;
    check_eq("reset_outputs", obs(), {5'd0, 1'b0, 15'd0, 5'b01000, 3'b000, 3'b000});
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("ready_after_release", {31'd0, instr_ready}, 32'd1);

    run_instr(32'h002081B3, -1);
    run_instr(32'h407302B3, -1);
    run_instr(32'h00812203, -1);
    run_instr(32'h0050A623, -1);
    run_instr(32'h00000033, -1);
    run_instr(32'h00208463, 1);
    run_instr(32'h00208463, 0);
    run_instr(32'h00209463, 1);
    run_instr(32'h00209463, 0);
    run_instr(32'h0020A1B3, -1);
    run_instr(32'h40005013, -1);
    run_instr(32'h40001013, -1);
    run_instr(32'h40000013, -1);

    for (int i = 0; i < 400; i++) run_instr(rand_instr(), -1);

    // lw interrupted by reset while in MEMORY
    instruction = 32'h00812203;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_eq("mem_ctrl3", {31'd0, ctrl3}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check_eq("reset_in_mem", obs(), {5'd0, 1'b0, 15'd0, 5'b01000, 3'b000, 3'b000});
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("ready_after_mem_reset", {31'd0, instr_ready}, 32'd1);
    run_instr(32'h002081B3, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control FSM that drives the processor datapath's control inputs. It accepts one RV32I instruction per handshake, decodes it, and sequences the datapath over 1–4 cycles. Outputs per cycle are register addresses, `ctrl0`..`ctrl4` and `ALUOp`. It samples the datapath's `ZeroFlag` to resolve branches and reports completion, branch outcome and illegal encodings to the fetch stage.

## Interface
Parameters: none (ISA subset fixed).

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; forces IDLE and clears IR.
- `instruction` in 32: instruction word from fetch, valid with `instr_valid`.
- `instr_valid` in 1: fetch offers an instruction.
- `instr_ready` out 1: controller accepts; transfer when `instr_valid && instr_ready`.
- `zero_flag` in 1: datapath ALU zero result.
- `reg1_addr` out 5: rs1 = IR[19:15].
- `reg2_addr` out 5: rs2 = IR[24:20].
- `write_reg_addr` out 5: rd = IR[11:7].
- `ctrl0` out 1: regfile write enable.
- `ctrl1` out 1: writeback mux; 1 = ALU result, 0 = memory data.
- `ctrl2` out 1: ALU B mux; 1 = immediate, 0 = rs2.
- `ctrl3` out 1: memory read.
- `ctrl4` out 1: memory write.
- `ALUOp` out 3: 000 add, 001 sub, 010 sll, 011 srl, 100 sra, 101 and, 110 or, 111 xor.
- `done` out 1: one-cycle pulse in the final cycle of every instruction.
- `branch_taken` out 1: valid only with `done` for branches; 0 otherwise.
- `illegal` out 1: one-cycle pulse with `done` on an unsupported encoding.

## Operation
- IR (32 b) is loaded on handshake. All outputs are combinational from state and IR; addresses come from IR at all times.
- States are IDLE, DECODE, EXECUTE, MEMORY and WRITEBACK.
- IDLE: `instr_ready`=1. On handshake, load IR and go to DECODE. Otherwise stay.
- DECODE: classify the opcode. If the encoding is illegal, pulse `done` and `illegal`, then go to IDLE. Otherwise go to EXECUTE.
- Supported instructions:
  - R-type 0110011, funct3→ALUOp:
    - 000 → add, or sub if funct7=0100000.
    - 001 → sll; 100 → xor; 110 → or; 111 → and.
    - 101 → srl, or sra if funct7=0100000.
    - funct7 must be 0000000, or 0100000 only for sub/sra.
  - I-arith 0010011: same funct3 map. addi/xori/ori/andi ignore IR[31:25]. slli/srli need IR[31:25]=0000000; srai needs 0100000.
  - Load 0000011 with funct3=010 (lw).
  - Store 0100011 with funct3=010 (sw).
  - Branch 1100011 with funct3 000 (beq) or 001 (bne).
  - Any other opcode or funct combination is illegal (e.g. slt/sltu, lb/sb, lui, jal).
- EXECUTE:
  - `ctrl2`=1 for I-arith, load and store; 0 for R-type and branch.
  - ALUOp = decoded op; add for load/store; sub for branch.
  - Branch: `branch_taken` = `zero_flag` for beq, `!zero_flag` for bne; pulse `done`; go to IDLE.
  - R-type and I-arith go to WRITEBACK; load and store go to MEMORY.
- MEMORY: ALUOp/`ctrl2` held. Load: `ctrl3`=1, go to WRITEBACK. Store: `ctrl4`=1 for this single cycle, pulse `done`, go to IDLE.
- WRITEBACK:
  - `ctrl0`=1 unless rd=0; no write to x0 is ever issued.
  - `ctrl1`=1 for ALU ops; load uses `ctrl1`=0 and keeps `ctrl3`=1.
  - ALUOp/`ctrl2` held; pulse `done`; go to IDLE.
- Defaults outside the listed assertions:
  - `ctrl0`=`ctrl3`=`ctrl4`=0.
  - `ctrl1`=1, `ctrl2`=0, ALUOp=000.
  - `done`=`branch_taken`=`illegal`=0.
- ALUOp and `ctrl2` are stable from EXECUTE through the final state of each instruction.

## Timing
- Cycle count runs from the handshake edge (IR loaded) to the `done` cycle, inclusive of the DECODE cycle:
  - illegal 1; branch 2; store 3; R/I-arith 3; load 4.
- `instr_ready` is low in all non-IDLE states, so there is no back-to-back acceptance. The next handshake occurs the cycle after `done` at the earliest.
- `ctrl0` and `ctrl4` are high for exactly one cycle per instruction (or zero cycles); never both.
- `zero_flag` is sampled only in EXECUTE of a branch.
- Reset asserted at any point: immediate IDLE, IR=0, all outputs at defaults, no pending write completes.
  - `instr_ready`=0 while `reset` is high, and 1 from the first cycle after release.
- Outputs from reset: addresses 0, `ctrl1`=1, everything else 0.

## Test plan
- Load 0x002081B3 (add x3,x1,x2) -> D/E/W over 3 cycles: ALUOp=000, `ctrl2`=0, addrs 1/2/3. W: `ctrl0`=1, `ctrl1`=1, `done`=1.
- Load 0x407302B3 (sub x5,x6,x7) -> ALUOp=001. Then 0x00812203 (lw x4,8(x2)) -> 4 cycles: `ctrl2`=1, ALUOp=000, `ctrl3`=1 in M and W, W: `ctrl1`=0 and `ctrl0`=1.
- Load 0x0050A623 (sw x5,12(x1)) -> `ctrl4`=1 only in M, `done` in M, `ctrl0` never high. 0x00000033 (add x0,x0,x0) -> W with `ctrl0`=0 and `done`=1.
- Load 0x00208463 (beq x1,x2,8) with `zero_flag`=1 -> `done`+`branch_taken`=1 after 2 cycles. Repeat with `zero_flag`=0 -> `branch_taken`=0. Same word with funct3=001 inverts both results.
- Load 0x0020A1B3 (slt) -> `illegal`+`done` in DECODE, no ctrl asserted, `instr_ready`=1 next cycle.
- Raise `reset` during MEMORY of the lw -> same cycle `ctrl3`=0 and state IDLE. After release, `instr_ready`=1 and the next add completes normally in 3 cycles.
